// File: rtl/imem_loadable_pkg.sv
// ============================================================================
// imem_pkg: shared types and constants for the loadable instruction memory.
// Revision: 1.0
// ============================================================================
`default_nettype none

package imem_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} ld_state_t;
  localparam logic [31:0] NOP_WORD = 32'hE1A00000;
endpackage

`default_nettype wire

// File: rtl/imem_loadable_if.sv
// ============================================================================
// imem_loadable_if: load-port bundle (start/size, valid/ready beats, status).
// Revision: 1.0
// ============================================================================
`default_nettype none

interface imem_loadable_if #(
  parameter int AW = 7
);
  logic          ld_start;
  logic [AW-1:0] ld_base;
  logic [AW:0]   ld_len;
  logic          ld_valid;
  logic [31:0]   ld_data;
  logic          ld_ready;
  logic          ld_done;
  logic          ld_err;
  logic [31:0]   ld_sum;

  modport master (
    output ld_start, ld_base, ld_len, ld_valid, ld_data,
    input  ld_ready, ld_done, ld_err, ld_sum
  );

  modport slave (
    input  ld_start, ld_base, ld_len, ld_valid, ld_data,
    output ld_ready, ld_done, ld_err, ld_sum
  );
endinterface

`default_nettype wire

// File: rtl/imem_loadable_load_ctrl.sv
// ============================================================================
// imem_load_ctrl: loader FSM, write pointer, remaining count, sum and flags.
// Revision: 1.0
// ============================================================================
`default_nettype none

module imem_load_ctrl
  import imem_pkg::*;
#(
  parameter int DEPTH     = 128,
  parameter int AW        = $clog2(DEPTH),
  parameter bit BOOT_HOLD = 1'b1
) (
  input  wire logic          clk,
  input  wire logic          reset_n,
  imem_loadable_if.slave     ld,
  output logic               we,
  output logic [AW-1:0]      waddr,
  output logic [31:0]        wdata,
  output logic               cpu_hold
);

  localparam logic [AW+1:0] DEPTH_EXT = (AW+2)'(DEPTH);
  localparam logic [AW:0]   REM_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  ld_state_t     r_state, w_next;
  logic [AW-1:0] r_ptr;
  logic [AW:0]   r_rem;
  logic [31:0]   r_sum;
  logic          r_done, r_err;

  logic [AW+1:0] w_end;
  logic          w_over, w_empty, w_start, w_beat, w_last;

  // Range check is done one bit wider than the length so base+len cannot wrap.
  assign w_end   = {2'b00, ld.ld_base} + {1'b0, ld.ld_len};
  assign w_over  = w_end > DEPTH_EXT;
  assign w_empty = (ld.ld_len == '0);
  assign w_start = ld.ld_start && (r_state != LOAD);
  assign w_beat  = ld.ld_valid && (r_state == LOAD);
  assign w_last  = w_beat && (r_rem == REM_ONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    ld.ld_ready = 1'b0;
    cpu_hold    = BOOT_HOLD;
    if (w_start)     w_next = w_over ? ERR : (w_empty ? DONE : LOAD);
    else if (w_last) w_next = DONE;
    case (r_state)
      LOAD: begin
        ld.ld_ready = 1'b1;
        cpu_hold    = 1'b1;
      end
      ERR:     cpu_hold = 1'b1;
      DONE:    cpu_hold = 1'b0;
      default: cpu_hold = BOOT_HOLD;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr  <= '0;
      r_rem  <= '0;
      r_sum  <= '0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else if (w_start) begin
      r_ptr  <= ld.ld_base;
      r_rem  <= ld.ld_len;
      r_done <= !w_over && w_empty;
      r_err  <= w_over;
      if (!w_over) r_sum <= '0;
    end else if (w_beat) begin
      r_ptr <= r_ptr + PTR_ONE;
      r_rem <= r_rem - REM_ONE;
      r_sum <= r_sum + ld.ld_data;
      if (w_last) r_done <= 1'b1;
    end
  end

  assign we        = w_beat;
  assign waddr     = r_ptr;
  assign wdata     = ld.ld_data;
  assign ld.ld_sum  = r_sum;
  assign ld.ld_done = r_done;
  assign ld.ld_err  = r_err;

endmodule

`default_nettype wire

// File: rtl/imem_loadable.sv
// ============================================================================
// imem_loadable: word-addressed instruction store, async fetch, streamed load.
// Revision: 1.0
// ============================================================================
`default_nettype none

module imem_loadable
  import imem_pkg::*;
#(
  parameter int          DEPTH     = 128,
  parameter int          AW        = $clog2(DEPTH),
  parameter logic [31:0] FILL      = NOP_WORD,
  parameter bit          BOOT_HOLD = 1'b1
) (
  input  wire logic        clk,
  input  wire logic        reset_n,
  input  wire logic [31:0] a,
  output logic [31:0]      rd,
  output logic             rd_misalign,
  output logic             cpu_hold,
  imem_loadable_if.slave   ld
);

  logic [31:0]   mem [DEPTH];
  logic          w_we;
  logic [AW-1:0] w_waddr;
  logic [31:0]   w_wdata;
  logic          w_in_range;

  imem_load_ctrl #(
    .DEPTH     (DEPTH),
    .AW        (AW),
    .BOOT_HOLD (BOOT_HOLD)
  ) u_ctrl (
    .clk      (clk),
    .reset_n  (reset_n),
    .ld       (ld),
    .we       (w_we),
    .waddr    (w_waddr),
    .wdata    (w_wdata),
    .cpu_hold (cpu_hold)
  );

  // Array is deliberately unreset so a program survives a core reset.
  always_ff @(posedge clk) begin
    if (w_we) mem[w_waddr] <= w_wdata;
  end

  assign w_in_range  = (a[31:AW+2] == '0);
  assign rd          = w_in_range ? mem[a[AW+1:2]] : FILL;
  assign rd_misalign = (a[1:0] != 2'b00);

endmodule

`default_nettype wire

// File: tb/tb_imem_loadable.sv
// ============================================================================
// tb_imem_loadable: vector table, directed corner sequences and random loads.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_imem_loadable;
  localparam int          DEPTH = 128;
  localparam int          AW    = 7;
  localparam logic [31:0] FILLW = 32'hE1A00000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] rd;
  logic        rd_misalign;
  logic        cpu_hold;

  imem_loadable_if #(.AW(AW)) ld_if ();

  imem_loadable #(.DEPTH(DEPTH), .FILL(FILLW), .BOOT_HOLD(1'b1)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .a           (a),
    .rd          (rd),
    .rd_misalign (rd_misalign),
    .cpu_hold    (cpu_hold),
    .ld          (ld_if.slave)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model_mem [DEPTH];
  bit          known     [DEPTH];
  logic [31:0] model_sum = '0;
  logic [31:0] pend [$];

  typedef struct {
    logic [31:0] addr;
    bit          use_mem;
    int          idx;
    logic        exp_mis;
  } vec_t;
  vec_t tv [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
    a = addr;
    #1;
    chk(name, rd, exp);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rst ready", 32'(ld_if.ld_ready), 32'd0);
    chk("rst done", 32'(ld_if.ld_done), 32'd0);
    chk("rst err", 32'(ld_if.ld_err), 32'd0);
    chk("rst sum", ld_if.ld_sum, 32'd0);
    chk("rst hold", 32'(cpu_hold), 32'd1);
    model_sum = '0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // gap_mode: 0 back-to-back, 1 one idle cycle between beats, 2 random idles
  task automatic run_load(input int base, input int len, input int gap_mode);
    bit exp_err;
    exp_err = (base + len) > DEPTH;
    @(negedge clk);
    ld_if.ld_start = 1'b1;
    ld_if.ld_base  = AW'(base);
    ld_if.ld_len   = (AW+1)'(len);
    ld_if.ld_valid = 1'b0;
    @(negedge clk);
    ld_if.ld_start = 1'b0;
    if (exp_err) begin
      chk("err flag", 32'(ld_if.ld_err), 32'd1);
      chk("err done", 32'(ld_if.ld_done), 32'd0);
      chk("err ready", 32'(ld_if.ld_ready), 32'd0);
      chk("err hold", 32'(cpu_hold), 32'd1);
      ld_if.ld_valid = 1'b1;
      ld_if.ld_data  = $urandom;
      a = 32'(base) * 4;
      @(negedge clk);
      ld_if.ld_valid = 1'b0;
      #1;
      chk("err no write", rd, model_mem[base]);
      chk("err sum kept", ld_if.ld_sum, model_sum);
      return;
    end
    model_sum = '0;
    if (len == 0) begin
      chk("len0 done", 32'(ld_if.ld_done), 32'd1);
      chk("len0 ready", 32'(ld_if.ld_ready), 32'd0);
      chk("len0 sum", ld_if.ld_sum, 32'd0);
      chk("len0 hold", 32'(cpu_hold), 32'd0);
      return;
    end
    chk("load ready", 32'(ld_if.ld_ready), 32'd1);
    chk("load sum clr", ld_if.ld_sum, 32'd0);
    chk("load hold", 32'(cpu_hold), 32'd1);
    for (int i = 0; i < len; i++) begin
      int gaps;
      gaps = (gap_mode == 1 && i > 0) ? 1 : (gap_mode == 2 ? int'($urandom_range(0, 2)) : 0);
      for (int g = 0; g < gaps; g++) begin
        ld_if.ld_valid = 1'b0;
        @(negedge clk);
        chk("gap ready", 32'(ld_if.ld_ready), 32'd1);
      end
      ld_if.ld_valid = 1'b1;
      ld_if.ld_data  = pend[i];
      a = 32'(base + i) * 4;
      #1;
      if (known[base+i]) chk("same-cycle old word", rd, model_mem[base+i]);
      chk("done low mid", 32'(ld_if.ld_done), 32'd0);
      @(negedge clk);
      model_mem[base+i] = pend[i];
      known[base+i]     = 1'b1;
      model_sum         = model_sum + pend[i];
    end
    ld_if.ld_valid = 1'b0;
    chk("done", 32'(ld_if.ld_done), 32'd1);
    chk("done err", 32'(ld_if.ld_err), 32'd0);
    chk("done ready", 32'(ld_if.ld_ready), 32'd0);
    chk("done hold", 32'(cpu_hold), 32'd0);
    chk("sum", ld_if.ld_sum, model_sum);
    #1;
    chk("last word", rd, model_mem[base+len-1]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_rd;
    logic [31:0] sum_b2b;
    int          base, len, idx;
    logic [1:0]  lo;

    tv[0] = '{32'h0000_0000, 1'b1, 0,   1'b0};
    tv[1] = '{32'h0000_0004, 1'b1, 1,   1'b0};
    tv[2] = '{32'h0000_0006, 1'b1, 1,   1'b1};
    tv[3] = '{32'h0000_01FC, 1'b1, 127, 1'b0};
    tv[4] = '{32'h0000_01FF, 1'b1, 127, 1'b1};
    tv[5] = '{32'h0000_0200, 1'b0, 0,   1'b0};
    tv[6] = '{32'h8000_0000, 1'b0, 0,   1'b0};
    tv[7] = '{32'h0000_0203, 1'b0, 0,   1'b1};

    ld_if.ld_start = 1'b0;
    ld_if.ld_base  = '0;
    ld_if.ld_len   = '0;
    ld_if.ld_valid = 1'b0;
    ld_if.ld_data  = '0;
    for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;

    #1;
    chk("por hold", 32'(cpu_hold), 32'd1);
    chk("por ready", 32'(ld_if.ld_ready), 32'd0);
    reset_pulse();

    run_load(5, 0, 0);

    pend.delete();
    for (int i = 0; i < DEPTH; i++) pend.push_back($urandom);
    run_load(0, DEPTH, 2);

    for (int i = 0; i < 8; i++) begin
      exp_rd = tv[i].use_mem ? model_mem[tv[i].idx] : FILLW;
      rd_chk($sformatf("vec%0d rd", i), tv[i].addr, exp_rd);
      chk($sformatf("vec%0d mis", i), 32'(rd_misalign), 32'(tv[i].exp_mis));
    end

    pend.delete();
    pend.push_back(32'hE3A09000);
    pend.push_back(32'hE3A000C8);
    pend.push_back(32'hE3A02014);
    run_load(0, 3, 0);
    sum_b2b = 32'hE3A09000 + 32'hE3A000C8 + 32'hE3A02014;
    chk("b2b sum", ld_if.ld_sum, sum_b2b);
    rd_chk("b2b w0", 32'h0, 32'hE3A09000);
    rd_chk("b2b w1", 32'h4, 32'hE3A000C8);
    rd_chk("b2b w2", 32'h8, 32'hE3A02014);

    run_load(0, 3, 1);
    chk("toggle sum", ld_if.ld_sum, sum_b2b);
    rd_chk("toggle w0", 32'h0, 32'hE3A09000);
    rd_chk("toggle w2", 32'h8, 32'hE3A02014);

    pend.delete();
    pend.push_back(32'h1111_1111);
    pend.push_back(32'h2222_2222);
    pend.push_back(32'h3333_3333);
    run_load(126, 3, 0);
    rd_chk("err keep 126", 32'd126 * 4, model_mem[126]);
    rd_chk("err keep 127", 32'd127 * 4, model_mem[127]);
    run_load(126, 2, 0);

    // Reset in the middle of a four-word load, with an ignored re-start.
    pend.delete();
    for (int i = 0; i < 4; i++) pend.push_back($urandom);
    @(negedge clk);
    ld_if.ld_start = 1'b1;
    ld_if.ld_base  = 7'd10;
    ld_if.ld_len   = 8'd4;
    @(negedge clk);
    ld_if.ld_start = 1'b0;
    model_sum = '0;
    for (int i = 0; i < 2; i++) begin
      ld_if.ld_valid = 1'b1;
      ld_if.ld_data  = pend[i];
      @(negedge clk);
      model_mem[10+i] = pend[i];
      model_sum       = model_sum + pend[i];
    end
    ld_if.ld_valid = 1'b0;
    ld_if.ld_start = 1'b1;
    ld_if.ld_base  = 7'd0;
    ld_if.ld_len   = 8'd0;
    @(negedge clk);
    ld_if.ld_start = 1'b0;
    chk("restart ignored ready", 32'(ld_if.ld_ready), 32'd1);
    chk("restart ignored done", 32'(ld_if.ld_done), 32'd0);
    chk("partial sum", ld_if.ld_sum, model_sum);
    reset_pulse();
    rd_chk("abort w0", 32'd40, model_mem[10]);
    rd_chk("abort w1", 32'd44, model_mem[11]);
    rd_chk("abort old", 32'd48, model_mem[12]);
    chk("abort idle hold", 32'(cpu_hold), 32'd1);

    for (int it = 0; it < 25; it++) begin
      base = $urandom_range(0, DEPTH - 1);
      len  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, DEPTH)) : int'($urandom_range(0, 8));
      pend.delete();
      for (int i = 0; i < len; i++) pend.push_back($urandom);
      run_load(base, len, 2);
      for (int k = 0; k < 4; k++) begin
        idx = $urandom_range(0, DEPTH - 1);
        lo  = 2'($urandom_range(0, 3));
        rd_chk("rand rd", (32'(idx) * 4) | 32'(lo), model_mem[idx]);
        chk("rand mis", 32'(rd_misalign), 32'(lo != 2'b00));
      end
      rd_chk("rand oor", 32'h0000_0200 + 32'($urandom_range(0, 1000)) * 4, FILLW);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
